// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// FSM encodings, grant bit positions and default timing parameters.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam int GRANT_DATA = 0;
    localparam int GRANT_CMD  = 1;

    localparam int DEFAULT_GAP_CYCLES = 4;
    localparam int DEFAULT_MAX_BYTES  = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. A tie goes to the requester that did not own last;
// the last owner is remembered only when the caller accepts the pick.
module rr_arbiter2
    import uart_tx_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] pick
);

    // 0 = data owned last, 1 = cmd owned last
    logic last_owner;

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_owner ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b0;
        end else if (take && (pick != 2'b00)) begin
            last_owner <= pick[GRANT_CMD];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between a data-path and a command requester.
// Owner streams bytes one per two cycles, capped per grant, then a quiet gap follows.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int MAX_BYTES  = DEFAULT_MAX_BYTES
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       DataReq,
    input  logic [7:0] DataByte,
    output logic       DataLoaded,
    input  logic       CmdReq,
    input  logic [7:0] CmdByte,
    output logic       CmdLoaded,
    input  logic       TxReady,
    output logic       TxLoad,
    output logic [7:0] TxData,
    output logic [1:0] Grant,
    output arb_state_t DbgState
);

    localparam logic [7:0]  MAX_B    = 8'(MAX_BYTES);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    arb_state_t  state, state_n;
    logic [1:0]  grant, grant_n;
    logic        tx_load, tx_load_n;
    logic [7:0]  tx_data, tx_data_n;
    logic        data_loaded, data_loaded_n;
    logic        cmd_loaded, cmd_loaded_n;
    logic [7:0]  byte_cnt, byte_cnt_n;
    logic [15:0] gap_cnt, gap_cnt_n;

    logic        take;
    logic [1:0]  pick;
    logic        owner_req;
    logic [7:0]  owner_byte;

    rr_arbiter2 u_rr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .req   ({CmdReq, DataReq}),
        .take  (take),
        .pick  (pick)
    );

    assign owner_req  = grant[GRANT_DATA] ? DataReq  : (grant[GRANT_CMD] & CmdReq);
    assign owner_byte = grant[GRANT_DATA] ? DataByte : CmdByte;

    always_comb begin
        state_n       = state;
        grant_n       = grant;
        tx_load_n     = 1'b0;
        tx_data_n     = tx_data;
        data_loaded_n = 1'b0;
        cmd_loaded_n  = 1'b0;
        byte_cnt_n    = byte_cnt;
        gap_cnt_n     = gap_cnt;
        take          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    take       = 1'b1;
                    grant_n    = pick;
                    byte_cnt_n = 8'd0;
                    state_n    = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!owner_req) begin
                    grant_n   = 2'b00;
                    gap_cnt_n = 16'd0;
                    state_n   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else if (TxReady) begin
                    tx_load_n     = 1'b1;
                    tx_data_n     = owner_byte;
                    data_loaded_n = grant[GRANT_DATA];
                    cmd_loaded_n  = grant[GRANT_CMD];
                    byte_cnt_n    = byte_cnt + 8'd1;
                    state_n       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Cap reached: give the other requester a chance even if still asked
                if (byte_cnt >= MAX_B) begin
                    grant_n   = 2'b00;
                    gap_cnt_n = 16'd0;
                    state_n   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_n = ST_OWN;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = 16'd0;
                    state_n   = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            grant       <= 2'b00;
            tx_load     <= 1'b0;
            tx_data     <= 8'h00;
            data_loaded <= 1'b0;
            cmd_loaded  <= 1'b0;
            byte_cnt    <= 8'd0;
            gap_cnt     <= 16'd0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            tx_load     <= tx_load_n;
            tx_data     <= tx_data_n;
            data_loaded <= data_loaded_n;
            cmd_loaded  <= cmd_loaded_n;
            byte_cnt    <= byte_cnt_n;
            gap_cnt     <= gap_cnt_n;
        end
    end

    assign Grant      = grant;
    assign TxLoad     = tx_load;
    assign TxData     = tx_data;
    assign DataLoaded = data_loaded;
    assign CmdLoaded  = cmd_loaded;
    assign DbgState   = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default instance plus a MAX_BYTES=3 instance
// sharing the same stimulus; outputs of the instance under test are selected by sel.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    logic       Clk;
    logic       Reset_n;
    logic       DataReq, CmdReq, TxReady;
    logic [7:0] DataByte, CmdByte;

    logic       data_loaded_d, cmd_loaded_d, tx_load_d;
    logic [7:0] tx_data_d;
    logic [1:0] grant_d;
    arb_state_t state_d;

    logic       data_loaded_c, cmd_loaded_c, tx_load_c;
    logic [7:0] tx_data_c;
    logic [1:0] grant_c;
    arb_state_t state_c;

    logic       sel;
    logic       data_loaded, cmd_loaded, tx_load;
    logic [7:0] tx_data;
    logic [1:0] grant;
    arb_state_t state;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic [7:0] data_src[$];
    logic [7:0] cmd_src[$];
    logic [7:0] junk;

    uart_tx_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .DataReq(DataReq), .DataByte(DataByte), .DataLoaded(data_loaded_d),
        .CmdReq(CmdReq), .CmdByte(CmdByte), .CmdLoaded(cmd_loaded_d),
        .TxReady(TxReady), .TxLoad(tx_load_d), .TxData(tx_data_d),
        .Grant(grant_d), .DbgState(state_d)
    );

    uart_tx_arbiter #(.GAP_CYCLES(4), .MAX_BYTES(3)) dut_cap (
        .Clk(Clk), .Reset_n(Reset_n),
        .DataReq(DataReq), .DataByte(DataByte), .DataLoaded(data_loaded_c),
        .CmdReq(CmdReq), .CmdByte(CmdByte), .CmdLoaded(cmd_loaded_c),
        .TxReady(TxReady), .TxLoad(tx_load_c), .TxData(tx_data_c),
        .Grant(grant_c), .DbgState(state_c)
    );

    assign data_loaded = sel ? data_loaded_c : data_loaded_d;
    assign cmd_loaded  = sel ? cmd_loaded_c  : cmd_loaded_d;
    assign tx_load     = sel ? tx_load_c     : tx_load_d;
    assign tx_data     = sel ? tx_data_c     : tx_data_d;
    assign grant       = sel ? grant_c       : grant_d;
    assign state       = sel ? state_c       : state_d;

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic push_data(input logic [7:0] b);
        data_src.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic push_cmd(input logic [7:0] b);
        cmd_src.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(state == ST_IDLE && exp_q.size() == 0 && data_src.size() == 0 &&
                 cmd_src.size() == 0) && n < 300) begin
            wait_cycles(1);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("idle_state", state, ST_IDLE);
    endtask

    task automatic do_reset(input logic use_cap);
        Reset_n = 1'b0;
        exp_q.delete();
        data_src.delete();
        cmd_src.delete();
        sel = use_cap;
        wait_cycles(2);
        Reset_n = 1'b1;
        wait_cycles(1);
    endtask

    // scoreboard on loads, then requester model reacting to Loaded pulses
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset_n) begin
                if (tx_load) begin
                    if (exp_q.size() == 0) check("tx_unexpected", 1, 0);
                    else check("tx_data", tx_data, exp_q.pop_front());
                    check("loaded_owner", {30'd0, cmd_loaded, data_loaded}, {30'd0, grant});
                end else begin
                    check("loaded_quiet", {30'd0, cmd_loaded, data_loaded}, 0);
                end
            end
            if (data_loaded && data_src.size() != 0) junk = data_src.pop_front();
            if (cmd_loaded && cmd_src.size() != 0) junk = cmd_src.pop_front();
            DataReq  = (data_src.size() != 0);
            DataByte = DataReq ? data_src[0] : 8'h00;
            CmdReq   = (cmd_src.size() != 0);
            CmdByte  = CmdReq ? cmd_src[0] : 8'h00;
        end
    end

    initial begin
        logic [7:0] a_bytes [4];
        a_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        checks   = 0;
        errors   = 0;
        sel      = 1'b0;
        Reset_n  = 1'b0;
        DataReq  = 1'b0;
        CmdReq   = 1'b0;
        DataByte = 8'h00;
        CmdByte  = 8'h00;
        TxReady  = 1'b1;

        wait_cycles(2);
        check("rst_grant", grant, 2'b00);
        check("rst_txload", tx_load, 0);
        check("rst_txdata", tx_data, 8'h00);
        check("rst_loaded", {30'd0, cmd_loaded, data_loaded}, 0);
        check("rst_state", state, ST_IDLE);
        Reset_n = 1'b1;
        wait_cycles(1);

        // tie straight after reset: cmd first, data after gap
        push_cmd(8'hC1);
        push_cmd(8'hC2);
        push_data(8'hD1);
        wait_cycles(1);
        check("tie_grant_cmd", grant, 2'b10);
        wait_cycles(1);
        check("tie_load1", tx_load, 1);
        check("tie_data1", tx_data, 8'hC1);
        check("tie_cmdloaded", cmd_loaded, 1);
        wait_cycles(4);
        check("tie_release", grant, 2'b00);
        check("tie_gap", state, ST_GAP);
        wait_cycles(4);
        check("tie_idle", state, ST_IDLE);
        wait_cycles(1);
        check("tie_grant_data", grant, 2'b01);
        wait_idle();

        // single data burst at full rate
        for (int i = 0; i < 4; i++) push_data(a_bytes[i]);
        wait_cycles(1);
        check("burst_grant", grant, 2'b01);
        check("burst_noload", tx_load, 0);
        for (int i = 0; i < 4; i++) begin
            wait_cycles(1);
            check("burst_load", tx_load, 1);
            check("burst_byte", tx_data, a_bytes[i]);
            check("burst_dloaded", data_loaded, 1);
            wait_cycles(1);
            check("burst_hold", tx_load, 0);
            check("burst_keep", tx_data, a_bytes[i]);
        end
        wait_cycles(1);
        check("burst_release", grant, 2'b00);
        wait_cycles(4);
        check("burst_idle", state, ST_IDLE);
        wait_idle();

        // backpressure for 10 cycles, then a single byte and request drop
        TxReady = 1'b0;
        push_data(8'hB1);
        wait_cycles(1);
        check("bp_grant", grant, 2'b01);
        for (int i = 0; i < 10; i++) begin
            wait_cycles(1);
            check("bp_stall", tx_load, 0);
        end
        TxReady = 1'b1;
        wait_cycles(1);
        check("bp_load", tx_load, 1);
        check("bp_byte", tx_data, 8'hB1);
        wait_cycles(1);
        check("drop_still_owned", grant, 2'b01);
        wait_cycles(1);
        check("drop_grant", grant, 2'b00);
        for (int i = 0; i < 4; i++) begin
            check("drop_gap", state, ST_GAP);
            wait_cycles(1);
        end
        check("drop_idle", state, ST_IDLE);
        wait_idle();

        // reset after the second byte of a burst
        for (int i = 0; i < 4; i++) push_data(8'hE1 + 8'(i));
        wait_cycles(4);
        check("mid_load2", tx_load, 1);
        check("mid_byte2", tx_data, 8'hE2);
        #1 Reset_n = 1'b0;
        #1;
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_txload", tx_load, 0);
        check("mid_rst_txdata", tx_data, 8'h00);
        check("mid_rst_loaded", {30'd0, cmd_loaded, data_loaded}, 0);
        check("mid_rst_state", state, ST_IDLE);
        exp_q.delete();
        data_src.delete();
        cmd_src.delete();
        wait_cycles(2);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cycles(1);
            check("post_rst_quiet", {29'd0, tx_load, grant}, 0);
        end

        // per-grant cap with MAX_BYTES=3, both requesters held high
        do_reset(1'b1);
        push_cmd(8'h31);
        push_cmd(8'h32);
        push_cmd(8'h33);
        push_data(8'h41);
        push_cmd(8'h34);
        wait_cycles(1);
        check("cap_grant_cmd", grant, 2'b10);
        wait_cycles(5);
        check("cap_load3", tx_load, 1);
        check("cap_byte3", tx_data, 8'h33);
        wait_cycles(1);
        check("cap_forced_release", grant, 2'b00);
        check("cap_gap", state, ST_GAP);
        wait_cycles(4);
        check("cap_idle", state, ST_IDLE);
        wait_cycles(1);
        check("cap_grant_data", grant, 2'b01);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 4, idle cycles inserted between releasing one grant and arbitrating again.
REQ-002 Parameter MAX_BYTES, default 64, bytes one owner may send per grant before forced release (1..255).
REQ-003 Clk  in  1  single clock; all state on rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 DataReq  in  1  data-path requester wants UART; held high for whole burst.
REQ-006 DataByte  in  8  data-path byte, valid while DataReq high.
REQ-007 DataLoaded  out  1  one-cycle pulse: DataByte consumed.
REQ-008 CmdReq  in  1  command/status requester wants UART; held high for whole burst.
REQ-009 CmdByte  in  8  command byte, valid while CmdReq high.
REQ-010 CmdLoaded  out  1  one-cycle pulse: CmdByte consumed.
REQ-011 TxReady  in  1  UART transmitter can accept a byte.
REQ-012 TxLoad  out  1  one-cycle pulse: TxData valid, UART must capture.
REQ-013 TxData  out  8  byte to UART.
REQ-014 Grant  out  2  one-hot owner, bit0 = data, bit1 = cmd; 00 = none.

Function
REQ-015 FSM states: IDLE, OWN, HOLD, GAP; all outputs registered.
REQ-016 IDLE: any request -> OWN next cycle with Grant set; one requester wins per round-robin rule.
REQ-017 Round-robin: both requesting in IDLE -> grant goes to requester not in LastOwner; LastOwner updated on each grant.
REQ-018 OWN: owner request high and TxReady high -> TxLoad=1, TxData=owner byte, owner Loaded=1 same cycle (registered, one pulse), ByteCount+1, go HOLD.
REQ-019 HOLD: exactly one cycle, no load; returns to OWN (lets TxReady and requester byte update).
REQ-020 OWN: owner request low -> release: Grant=00, go GAP.
REQ-021 ByteCount reaching MAX_BYTES after a load -> HOLD then forced release to GAP even if request still high.
REQ-022 GAP: counter runs GAP_CYCLES cycles with Grant=00, then IDLE; GAP_CYCLES=0 goes directly IDLE.
REQ-023 Non-owner request never produces Loaded, TxLoad, or affects TxData.
REQ-024 TxReady low in OWN: wait, no load, no timeout; request drop still releases.
REQ-025 Latency: request at IDLE cycle n -> Grant at n+1 -> earliest TxLoad at n+2; back-to-back bytes every 2 cycles max.
REQ-026 TxData holds last loaded value between loads; Loaded pulses never coincide for both requesters.
REQ-027 ByteCount 8 bits, cleared on every new grant; no wrap (MAX_BYTES <= 255).

Reset
REQ-028 Reset_n low: state IDLE, Grant=00, TxLoad=0, DataLoaded=0, CmdLoaded=0, TxData=0x00, ByteCount=0, GAP counter=0, LastOwner=data (so cmd wins first tie).
REQ-029 Reset asserted mid-burst aborts immediately; no partial pulse after deassertion; arbitration restarts from IDLE.

Structure
REQ-030 Shared package holds FSM state encodings, Grant bit indices, default GAP_CYCLES/MAX_BYTES.
REQ-031 One sub-module natural: rr_arbiter2 (2-way round-robin pick with LastOwner register); FSM and counters stay in uart_tx_arbiter.

Verification
REQ-032 Single data burst: DataReq high 4 bytes 0xA1..0xA4, TxReady=1 -> Grant=01, four TxLoad pulses 2 cycles apart, TxData A1,A2,A3,A4, four DataLoaded pulses.
REQ-033 Tie after reset: DataReq & CmdReq same cycle -> Grant=10 first; after cmd release + GAP, Grant=01.
REQ-034 Starvation cap: MAX_BYTES=3, CmdReq and DataReq held high -> 3 cmd bytes, release, GAP 4 cycles, then data granted.
REQ-035 Backpressure: TxReady=0 for 10 cycles while owned -> no TxLoad/Loaded; load on first cycle TxReady=1.
REQ-036 Reset mid-burst: Reset_n low after 2nd byte -> all outputs reset values within same cycle; no TxLoad until new grant.
REQ-037 Drop request: owner deasserts after 1 byte -> Grant=00 next cycle, GAP count 4, IDLE.
